// File: rtl/updown_seq_ctrl_pkg.sv
// Shared encodings for the up/down sequencer: command modes, FSM states
// and the command legality check.
// Imported by updown_seq_ctrl and its counter datapath.
package updown_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN_UP   = 3'd2,
    ST_RUN_DOWN = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

  // A command is rejected if it would walk away from its terminal value
  // (or, for bounce, has no room to move). Operands are zero-extended by
  // the caller so one function serves every WIDTH up to 32.
  function automatic logic cmd_is_illegal(input logic [1:0]  mode,
                                          input logic [31:0] start,
                                          input logic [31:0] limit);
    logic bad;
    bad = 1'b0;
    case (mode)
      MODE_UP:     bad = (start > limit);
      MODE_DOWN:   bad = (start < limit);
      MODE_BOUNCE: bad = (start >= limit);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/updown_seq_ctrl_cnt.sv
// Loadable up/down counter datapath: WIDTH-bit register, priority load > inc > dec.
// Ports: clk, rst (async, active-high, clears to 0), load/inc/dec enables,
//        din (load value), q (current count).
module updown_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (inc) begin
      q <= q + WIDTH'(1);
    end else if (dec) begin
      q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_seq_ctrl.sv
// Command-driven sequencer: accepts one command over valid/ready, loads the
// counter and steps it up, down or bouncing on a prescaled tick.
// Ports: cmd_* handshake in, pause/abort controls, outbit count out,
//        up/down step pulses, busy level, done/err one-cycle pulses.
module updown_seq_ctrl
  import updown_seq_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 1,
  parameter int REP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] outbit,
  output logic             up,
  output logic             down,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t           state, state_nx;
  mode_t            mode_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] limit_q;
  logic [REP_W-1:0] rep_q;
  logic [PW-1:0]    presc;

  logic             run;
  logic             accept;
  logic             tick;
  logic [WIDTH-1:0] down_target;
  logic             cnt_load, cnt_inc, cnt_dec, rep_dec;

  assign run       = (state == ST_RUN_UP) || (state == ST_RUN_DOWN);
  assign accept    = cmd_valid && (state == ST_IDLE);
  // abort outranks the tick, so an aborted cycle never steps the counter
  assign tick      = run && !pause && !abort && (presc == PRESC_LAST);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_LOAD) || run;
  // bounce returns to its start value; plain down stops at the limit
  assign down_target = (mode_q == MODE_BOUNCE) ? start_q : limit_q;

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    rep_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = cmd_is_illegal(cmd_mode, 32'(cmd_start), 32'(cmd_limit))
                     ? ST_ERR : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          state_nx = (mode_q == MODE_DOWN) ? ST_RUN_DOWN : ST_RUN_UP;
        end
      end
      ST_RUN_UP: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          // the terminal value is held for one full tick before turning
          if (outbit != limit_q) cnt_inc = 1'b1;
          else if (mode_q == MODE_BOUNCE) state_nx = ST_RUN_DOWN;
          else state_nx = ST_DONE;
        end
      end
      ST_RUN_DOWN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          if (outbit != down_target) begin
            cnt_dec = 1'b1;
          end else if (mode_q == MODE_BOUNCE) begin
            rep_dec  = 1'b1;
            state_nx = (rep_q <= REP_W'(1)) ? ST_DONE : ST_RUN_UP;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_UP;
      start_q <= '0;
      limit_q <= '0;
      rep_q   <= '0;
      presc   <= '0;
      up      <= 1'b0;
      down    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mode_q  <= mode_t'(cmd_mode);
        start_q <= cmd_start;
        limit_q <= cmd_limit;
        // zero repetitions still means one round trip
        rep_q   <= (cmd_reps == '0) ? REP_W'(1) : cmd_reps;
      end else if (rep_dec) begin
        rep_q <= rep_q - REP_W'(1);
      end
      if (state == ST_LOAD) begin
        presc <= '0;
      end else if (run && !pause && !abort) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      end
      // pulses line up with the cycle the new count is visible
      up   <= cnt_inc;
      down <= cnt_dec;
      done <= (state_nx == ST_DONE);
      err  <= (state_nx == ST_ERR);
    end
  end

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .dec  (cnt_dec),
    .din  (start_q),
    .q    (outbit)
  );

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Bench for updown_seq_ctrl: table of commands plus cycle-exact sequences.
// Two instances: TICK_DIV=1 (main) and TICK_DIV=3 (prescaler timing).
module tb_updown_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       v3 = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [3:0] cmd_start = 4'd0;
  logic [3:0] cmd_limit = 4'd0;
  logic [3:0] cmd_reps = 4'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  logic       rdy1, up1, dn1, busy1, done1, err1;
  logic [3:0] out1;
  logic       rdy3, up3, dn3, busy3, done3, err3;
  logic [3:0] out3;

  always #5 clk = ~clk;

  updown_seq_ctrl #(.WIDTH(4), .TICK_DIV(1), .REP_W(4)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_mode(cmd_mode), .cmd_start(cmd_start), .cmd_limit(cmd_limit),
    .cmd_reps(cmd_reps), .pause(pause), .abort(abort), .outbit(out1),
    .up(up1), .down(dn1), .busy(busy1), .done(done1), .err(err1));

  updown_seq_ctrl #(.WIDTH(4), .TICK_DIV(3), .REP_W(4)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3),
    .cmd_mode(cmd_mode), .cmd_start(cmd_start), .cmd_limit(cmd_limit),
    .cmd_reps(cmd_reps), .pause(pause), .abort(abort), .outbit(out3),
    .up(up3), .down(dn3), .busy(busy3), .done(done3), .err(err3));

  // event kinds on the scoreboard
  localparam int K_UP = 0, K_DN = 1, K_DONE = 2, K_ERR = 3;

  typedef struct { int kind; int val; } ev_t;
  typedef struct {
    int mode, start, limit, reps;
    int exp_err, exp_ups, exp_downs, exp_final;
  } vec_t;

  ev_t  sb[$];
  vec_t vt[12];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cnt_up = 0;
  int   cnt_dn = 0;
  int   model_out = 0;

  int a_out [1:6] = '{5, 6, 7, 8, 8, 8};
  int a_up  [1:6] = '{0, 1, 1, 1, 0, 0};
  int a_bsy [1:6] = '{1, 1, 1, 1, 0, 0};
  int a_don [1:6] = '{0, 0, 0, 0, 1, 0};
  int a_rdy [1:6] = '{0, 0, 0, 0, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Reference model: the full event stream a command should produce.
  task automatic push_model(input int mode, input int start, input int limit, input int reps);
    int n;
    bit ill;
    ill = (mode == 3) || (mode == 0 && start > limit) ||
          (mode == 1 && start < limit) || (mode == 2 && start >= limit);
    if (ill) begin
      push(K_ERR, model_out);
    end else if (mode == 0) begin
      for (int v = start + 1; v <= limit; v++) push(K_UP, v);
      push(K_DONE, limit);
    end else if (mode == 1) begin
      for (int v = start - 1; v >= limit; v--) push(K_DN, v);
      push(K_DONE, limit);
    end else begin
      n = (reps == 0) ? 1 : reps;
      for (int r = 0; r < n; r++) begin
        for (int v = start + 1; v <= limit; v++) push(K_UP, v);
        for (int v = limit - 1; v >= start; v--) push(K_DN, v);
      end
      push(K_DONE, start);
    end
  endtask

  // Advance to the next falling edge and pop any event the main DUT produced.
  task automatic step();
    int kind;
    ev_t e;
    @(negedge clk);
    if (!rst && (up1 || dn1 || done1 || err1)) begin
      kind = up1 ? K_UP : dn1 ? K_DN : done1 ? K_DONE : K_ERR;
      if (up1) cnt_up++;
      if (dn1) cnt_dn++;
      if (sb.size() == 0) begin
        check("sb_unexpected_event", kind, -1);
      end else begin
        e = sb.pop_front();
        check("sb_kind", kind, e.kind);
        check("sb_outbit", int'(out1), e.val);
      end
    end
  endtask

  task automatic drive_cmd(input int mode, input int start, input int limit, input int reps);
    cmd_mode  = 2'(mode);
    cmd_start = 4'(start);
    cmd_limit = 4'(limit);
    cmd_reps  = 4'(reps);
  endtask

  task automatic run_cmd(input int i);
    bit finished;
    bit busy_seen;
    vec_t v;
    v = vt[i];
    cnt_up = 0;
    cnt_dn = 0;
    push_model(v.mode, v.start, v.limit, v.reps);
    drive_cmd(v.mode, v.start, v.limit, v.reps);
    check($sformatf("v%0d_ready_before", i), int'(rdy1), 1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    finished  = done1 || err1;
    busy_seen = busy1;
    for (int c = 0; c < 300 && !finished; c++) begin
      step();
      if (busy1) busy_seen = 1'b1;
      if (done1 || err1) finished = 1'b1;
    end
    check($sformatf("v%0d_finished_in_budget", i), int'(finished), 1);
    step();
    check($sformatf("v%0d_ready_after", i), int'(rdy1), 1);
    check($sformatf("v%0d_final_outbit", i), int'(out1), v.exp_final);
    check($sformatf("v%0d_busy_seen", i), int'(busy_seen), 1 - v.exp_err);
    check($sformatf("v%0d_up_pulses", i), cnt_up, v.exp_ups);
    check($sformatf("v%0d_down_pulses", i), cnt_dn, v.exp_downs);
    check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
    model_out = int'(out1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last_dn;
    int n_dn3;
    int n_done3;
    int cyc;
    bit saw_done;

    //            mode st lim rep err ups dns final
    vt[0]  = '{0,  5,  8, 0, 0,  3,  0,  8};
    vt[1]  = '{1,  8,  3, 0, 0,  0,  5,  3};
    vt[2]  = '{2,  2,  4, 2, 0,  4,  4,  2};
    vt[3]  = '{2,  2,  4, 0, 0,  2,  2,  2};
    vt[4]  = '{3,  1,  2, 0, 1,  0,  0,  2};
    vt[5]  = '{0,  9,  3, 0, 1,  0,  0,  2};
    vt[6]  = '{1,  3,  9, 0, 1,  0,  0,  2};
    vt[7]  = '{2,  4,  4, 1, 1,  0,  0,  2};
    vt[8]  = '{0,  7,  7, 0, 0,  0,  0,  7};
    vt[9]  = '{1, 15,  0, 0, 0,  0, 15,  0};
    vt[10] = '{0,  0, 15, 0, 0, 15,  0, 15};
    vt[11] = '{2, 14, 15, 3, 0,  3,  3, 14};

    // reset state, before and after clock edges
    #1;
    check("rst_outbit", int'(out1), 0);
    check("rst_ready", int'(rdy1), 1);
    check("rst_busy", int'(busy1), 0);
    check("rst_pulses", int'({up1, dn1, done1, err1}), 0);
    step();
    step();
    check("rst_held_outbit", int'(out1), 0);
    check("rst_held_ready", int'(rdy1), 1);
    rst = 1'b0;
    step();

    // cycle-exact up 5->8
    push_model(0, 5, 8, 0);
    drive_cmd(0, 5, 8, 0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("upseq_e%0d_outbit", k), int'(out1), a_out[k]);
      check($sformatf("upseq_e%0d_up", k), int'(up1), a_up[k]);
      check($sformatf("upseq_e%0d_busy", k), int'(busy1), a_bsy[k]);
      check($sformatf("upseq_e%0d_done", k), int'(done1), a_don[k]);
      check($sformatf("upseq_e%0d_ready", k), int'(rdy1), a_rdy[k]);
    end
    check("upseq_sb_drained", sb.size(), 0);
    model_out = 8;

    for (int i = 0; i < 12; i++) run_cmd(i);

    // pause at 6 for five cycles, then abort at 7
    push(K_UP, 6);
    push(K_UP, 7);
    drive_cmd(0, 5, 9, 0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("pause_start_outbit", int'(out1), 6);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("pause_frozen_outbit", int'(out1), 6);
      check("pause_no_up", int'(up1), 0);
    end
    pause = 1'b0;
    step();
    check("pause_resume_outbit", int'(out1), 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_ready", int'(rdy1), 1);
    check("abort_busy", int'(busy1), 0);
    check("abort_outbit", int'(out1), 7);
    saw_done = done1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done1) saw_done = 1'b1;
    end
    check("abort_no_done", int'(saw_done), 0);
    check("abort_outbit_held", int'(out1), 7);
    check("abort_sb_drained", sb.size(), 0);
    model_out = 7;

    // prescaled down 8->3 on the TICK_DIV=3 instance
    drive_cmd(1, 8, 3, 0);
    v3 = 1'b1;
    step();
    v3 = 1'b0;
    last_dn = -1;
    n_dn3 = 0;
    n_done3 = 0;
    for (cyc = 1; cyc < 40; cyc++) begin
      step();
      check("div3_no_up", int'(up3), 0);
      if (dn3) begin
        n_dn3++;
        check("div3_down_value", int'(out3), 8 - n_dn3);
        if (last_dn < 0) check("div3_first_down_cycle", cyc, 4);
        else check("div3_down_spacing", cyc - last_dn, 3);
        last_dn = cyc;
      end
      if (done3) begin
        n_done3++;
        if (n_done3 == 1) check("div3_done_cycle", cyc, 19);
      end
    end
    check("div3_down_count", n_dn3, 5);
    check("div3_done_count", n_done3, 1);
    check("div3_final_outbit", int'(out3), 3);
    check("div3_ready", int'(rdy3), 1);

    // async reset mid-RUN_UP, asserted between clock edges
    push_model(0, 0, 15, 0);
    drive_cmd(0, 0, 15, 0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("prereset_busy", int'(busy1), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outbit", int'(out1), 0);
    check("async_rst_busy", int'(busy1), 0);
    check("async_rst_ready", int'(rdy1), 1);
    sb.delete();
    step();
    rst = 1'b0;
    model_out = 0;
    step();
    run_cmd(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
